// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame buffer: camera side fills the back bank, display side reads the front bank.
// Optional build macro FB_DECIMATE_EN: 2x2 decimation of a double-resolution input stream.
module frame_buffer_pingpong #(
  parameter int C_IMG_COLS = 640,
  parameter int C_IMG_ROWS = 480,
  parameter int C_IMG_PXLS = C_IMG_COLS * C_IMG_ROWS,
  parameter int C_NB_ADDR  = 19,
  parameter int C_NB_PIX   = 12,
  parameter int C_NB_DROP  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_sof,
  input  logic                 wr_valid,
  input  logic [C_NB_PIX-1:0]  wr_data,
  input  logic                 rd_sof,
  input  logic [C_NB_ADDR-1:0] rd_addr,
  output logic [C_NB_PIX-1:0]  rd_data,
  output logic                 rd_bank,
  output logic                 frame_ready,
  output logic [C_NB_DROP-1:0] drop_cnt
);

  localparam int C_DEPTH  = 2 * C_IMG_PXLS;
  localparam int C_NB_IDX = $clog2(C_DEPTH);
  localparam logic [C_NB_ADDR-1:0] LAST_PTR = C_NB_ADDR'(C_IMG_PXLS - 1);
  localparam logic [C_NB_ADDR:0]   PXLS_X   = (C_NB_ADDR + 1)'(C_IMG_PXLS);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;

  logic [C_NB_PIX-1:0]  mem [C_DEPTH];
  wstate_t              state, state_nxt;
  logic                 wr_bank;
  logic [C_NB_ADDR-1:0] wr_ptr, ptr_eff;
  logic                 swap, accept, drop, filling, keep, store, complete, wr_bank_eff;
  logic [C_NB_ADDR:0]   wr_sum, rd_sum;
  logic [C_NB_IDX-1:0]  wr_idx, rd_idx;

  // Swap and accept are resolved together so a same-cycle wr_sof lands in the new back bank
  always_comb begin
    swap        = rd_sof & frame_ready;
    accept      = wr_sof & (~frame_ready | swap);
    drop        = wr_sof & frame_ready & ~swap;
    filling     = accept | (state == W_FILL);
    ptr_eff     = accept ? '0 : wr_ptr;
    wr_bank_eff = wr_bank ^ swap;
    store       = filling & wr_valid & keep;
    complete    = store & (ptr_eff == LAST_PTR);
    state_nxt   = state;
    if (complete)    state_nxt = W_IDLE;
    else if (accept) state_nxt = W_FILL;
  end

`ifdef FB_DECIMATE_EN
  localparam int C_NB_COL = $clog2(2 * C_IMG_COLS);
  localparam int C_NB_ROW = $clog2(2 * C_IMG_ROWS);
  localparam logic [C_NB_COL-1:0] LAST_COL = C_NB_COL'(2 * C_IMG_COLS - 1);

  logic [C_NB_COL-1:0] col, col_eff;
  logic [C_NB_ROW-1:0] row, row_eff;

  always_comb begin
    col_eff = accept ? '0 : col;
    row_eff = accept ? '0 : row;
    keep    = ~col_eff[0] & ~row_eff[0];
  end

  // Position counters follow every input pixel, stored or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (filling & wr_valid) begin
      if (col_eff == LAST_COL) begin
        col <= '0;
        row <= row_eff + C_NB_ROW'(1);
      end else begin
        col <= col_eff + C_NB_COL'(1);
        row <= row_eff;
      end
    end else if (accept) begin
      col <= '0;
      row <= '0;
    end
  end
`else
  always_comb keep = 1'b1;
`endif

  always_comb begin
    wr_sum = wr_bank_eff ? (PXLS_X + {1'b0, ptr_eff}) : {1'b0, ptr_eff};
    rd_sum = rd_bank ? (PXLS_X + {1'b0, rd_addr}) : {1'b0, rd_addr};
    wr_idx = C_NB_IDX'(wr_sum);
    rd_idx = C_NB_IDX'(rd_sum);
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= W_IDLE;
      wr_ptr      <= '0;
      wr_bank     <= 1'b1;
      rd_bank     <= 1'b0;
      frame_ready <= 1'b0;
      drop_cnt    <= '0;
      rd_data     <= '0;
    end else begin
      state <= state_nxt;
      if (store)       wr_ptr <= complete ? '0 : ptr_eff + C_NB_ADDR'(1);
      else if (accept) wr_ptr <= '0;
      if (complete)  frame_ready <= 1'b1;
      else if (swap) frame_ready <= 1'b0;
      if (swap) begin
        rd_bank <= ~rd_bank;
        wr_bank <= ~wr_bank;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + C_NB_DROP'(1);
      // Read uses the pre-swap bank; addresses past the frame read as zero
      rd_data <= ({1'b0, rd_addr} < PXLS_X) ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Self-checking bench for frame_buffer_pingpong (4x2 frame) with a transaction-level reference model.
module tb_frame_buffer_pingpong;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int PXLS = COLS * ROWS;
  localparam int NB_ADDR = 4;
  localparam int NB_PIX = 12;
  localparam int NB_DROP = 8;
`ifdef FB_DECIMATE_EN
  localparam int DEC = 1;
`else
  localparam int DEC = 0;
`endif
  localparam int IN_PER_FRAME = DEC ? 4 * PXLS : PXLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_sof = 1'b0, wr_valid = 1'b0, rd_sof = 1'b0;
  logic [NB_PIX-1:0] wr_data = '0;
  logic [NB_ADDR-1:0] rd_addr = '0;
  logic [NB_PIX-1:0] rd_data;
  logic rd_bank, frame_ready;
  logic [NB_DROP-1:0] drop_cnt;

  frame_buffer_pingpong #(
    .C_IMG_COLS(COLS), .C_IMG_ROWS(ROWS), .C_NB_ADDR(NB_ADDR),
    .C_NB_PIX(NB_PIX), .C_NB_DROP(NB_DROP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_sof(rd_sof), .rd_addr(rd_addr), .rd_data(rd_data), .rd_bank(rd_bank),
    .frame_ready(frame_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which bank is shown, which is being filled, and what each holds
  int m_rdbank, m_wrbank, m_ready, m_drop, m_fill, m_ptr, m_col, m_row, m_rdata;
  int m_mem[2][PXLS];
  bit m_known[2][PXLS];
  bit m_rknown;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rdbank = 0; m_wrbank = 1; m_ready = 0; m_drop = 0;
    m_fill = 0; m_ptr = 0; m_col = 0; m_row = 0;
    m_rdata = 0; m_rknown = 1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < PXLS; a++) m_known[b][a] = 0;
  endtask

  task automatic model_cycle(input bit sof, input bit valid, input int data,
                             input bit rsof, input int raddr);
    bit swap, accept, completed, keep;
    int bank;
    swap = rsof && (m_ready == 1);
    accept = sof && (m_ready == 0 || swap);
    completed = 0;
    if (raddr >= PXLS) begin
      m_rdata = 0; m_rknown = 1;
    end else begin
      m_rdata = m_mem[m_rdbank][raddr]; m_rknown = m_known[m_rdbank][raddr];
    end
    if (sof && !accept && m_drop < 255) m_drop++;
    if (accept) begin
      m_fill = 1; m_ptr = 0; m_col = 0; m_row = 0;
    end
    bank = swap ? 1 - m_wrbank : m_wrbank;
    if (m_fill == 1 && valid) begin
      keep = 1;
      if (DEC == 1) begin
        keep = (m_col % 2 == 0) && (m_row % 2 == 0);
        m_col++;
        if (m_col == 2 * COLS) begin
          m_col = 0; m_row++;
        end
      end
      if (keep) begin
        m_mem[bank][m_ptr] = data & 'hFFF;
        m_known[bank][m_ptr] = 1;
        m_ptr++;
        if (m_ptr == PXLS) begin
          completed = 1; m_fill = 0; m_ptr = 0;
        end
      end
    end
    if (completed) m_ready = 1;
    else if (swap) m_ready = 0;
    if (swap) begin
      m_rdbank = 1 - m_rdbank; m_wrbank = 1 - m_wrbank;
    end
  endtask

  task automatic step(input bit sof, input bit valid, input int data,
                      input bit rsof, input int raddr);
    wr_sof = sof; wr_valid = valid; wr_data = NB_PIX'(data);
    rd_sof = rsof; rd_addr = NB_ADDR'(raddr);
    model_cycle(sof, valid, data, rsof, raddr);
    @(posedge clk);
    #1;
    chk("rd_bank", 32'(rd_bank), 32'(m_rdbank));
    chk("frame_ready", 32'(frame_ready), 32'(m_ready));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_rknown) chk("rd_data", 32'(rd_data), 32'(m_rdata));
    wr_sof = 0; wr_valid = 0; rd_sof = 0;
  endtask

  task automatic fill_frame(input int base);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < IN_PER_FRAME; i++) step(0, 1, base + i, 0, 0);
  endtask

  initial begin
    int exp_dec[PXLS];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_bank", 32'(rd_bank), 0);
    chk("reset_ready", 32'(frame_ready), 0);
    chk("reset_drop", 32'(drop_cnt), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    rst_n = 1;
    step(0, 0, 0, 0, 0);

`ifdef FB_DECIMATE_EN
    exp_dec = '{0, 2, 4, 6, 16, 18, 20, 22};
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4 * PXLS; i++) begin
      step(0, 1, i, 0, 0);
      if (i == 21) chk("dec_not_ready_21", 32'(frame_ready), 0);
      if (i == 22) chk("dec_ready_22", 32'(frame_ready), 1);
    end
    step(0, 0, 0, 1, 0);
    for (int a = 0; a < PXLS; a++) begin
      step(0, 0, 0, 0, a);
      chk("dec_bank_data", 32'(rd_data), 32'(exp_dec[a]));
    end
`else
    exp_dec = '{default: 0};
    // Fill and swap
    fill_frame(1);
    chk("fill_ready", 32'(frame_ready), 1);
    step(0, 0, 0, 1, 0);
    chk("swap_bank", 32'(rd_bank), 1);
    chk("swap_ready", 32'(frame_ready), 0);
    step(0, 0, 0, 0, 3);
    chk("read_addr3", 32'(rd_data), 32'h004);

    // Drops while a completed frame waits
    fill_frame('h100);
    step(1, 1, 'hFFF, 0, 0);
    chk("drop_one", 32'(drop_cnt), 1);
    step(0, 1, 'hEEE, 0, 1);
    step(1, 0, 0, 0, 2);
    step(1, 1, 'hDDD, 0, 3);
    chk("drop_three", 32'(drop_cnt), 3);
    for (int a = 0; a < PXLS; a++) begin
      step(0, 0, 0, 0, a);
      chk("bank1_kept", 32'(rd_data), 32'(a + 1));
    end

    // Swap, accept and pixel 0 in one cycle
    step(1, 1, 'hABC, 1, 0);
    chk("same_cycle_drop", 32'(drop_cnt), 3);
    chk("same_cycle_bank", 32'(rd_bank), 0);
    for (int i = 1; i < PXLS; i++) step(0, 1, 'h200 + i, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("same_cycle_pix0", 32'(rd_data), 32'hABC);

    // Restart mid-frame, then out-of-range read
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 'h300 + i, 0, 0);
    fill_frame('h010);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("restart_addr0", 32'(rd_data), 32'h010);
    step(0, 0, 0, 0, 9);
    chk("out_of_range", 32'(rd_data), 0);
`endif

    // Randomised traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, int'($urandom & 'hFFF),
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));

    // Asynchronous reset in the middle of a fill
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 'h400 + i, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("areset_rd_data", 32'(rd_data), 0);
    chk("areset_rd_bank", 32'(rd_bank), 0);
    chk("areset_ready", 32'(frame_ready), 0);
    chk("areset_drop", 32'(drop_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    fill_frame('h500);
    chk("post_reset_ready", 32'(frame_ready), 1);
    step(0, 0, 0, 1, 0);
    for (int a = 0; a < PXLS; a++) step(0, 0, 0, 0, a);
    chk("post_reset_bank", 32'(rd_bank), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer_pingpong.md
Name: frame_buffer_pingpong

Overview:
Double-buffered (ping-pong) successor to the single-bank frame buffer, parametrised in resolution and pixel width. The camera side streams pixels with frame-start framing and an internal write pointer, so it needs no external write address. The VGA side reads random addresses from the displayed bank. Banks swap only on a read-side frame boundary after a complete frame has been captured, so the display never shows a torn frame.

Parameters:
C_IMG_COLS, 640, stored columns per frame
C_IMG_ROWS, 480, stored rows per frame
C_IMG_PXLS, C_IMG_COLS*C_IMG_ROWS, pixels per bank
C_NB_ADDR, 19, pixel address width (must satisfy 2^C_NB_ADDR >= C_IMG_PXLS)
C_NB_PIX, 12, stored pixel width (RGB444 default)
C_NB_DROP, 8, width of dropped-frame counter

Ports:
clk  in  1  single system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_sof  in  1  one-cycle pulse, camera start of frame
wr_valid  in  1  wr_data holds a valid pixel this cycle
wr_data  in  C_NB_PIX  camera pixel
rd_sof  in  1  one-cycle pulse, display frame boundary (vsync)
rd_addr  in  C_NB_ADDR  display pixel address in the displayed bank
rd_data  out  C_NB_PIX  registered pixel read from the displayed bank
rd_bank  out  1  index of the displayed bank
frame_ready  out  1  completed frame waiting for swap
drop_cnt  out  C_NB_DROP  saturating count of dropped camera frames

Behaviour:
- Storage: one array of depth 2*C_IMG_PXLS; entry index = bank*C_IMG_PXLS + pointer. The array is not reset.
- Reset values: rd_bank=0, internal wr_bank=1, frame_ready=0, drop_cnt=0, rd_data=0, write FSM=W_IDLE, wr_ptr=0.
- Write FSM, W_IDLE: wr_sof is accepted when frame_ready=0, or when a swap happens in the same cycle. On accept: wr_ptr=0, go to W_FILL.
- If wr_sof arrives while frame_ready=1 and no swap happens that cycle, drop_cnt increments (saturating at all-ones) and the state stays W_IDLE. Pixels are ignored until the next accepted wr_sof.
- Write FSM, W_FILL: each wr_valid writes wr_data at wr_ptr in wr_bank, then wr_ptr increments.
- The write at wr_ptr=C_IMG_PXLS-1 sets frame_ready=1 and returns the FSM to W_IDLE. Extra pixels after that are ignored.
- wr_sof during W_FILL restarts at wr_ptr=0. The partial frame is discarded silently, with no drop count.
- Same-cycle wr_sof and wr_valid: the pixel is pixel 0 and is written at address 0 of the bank selected after any same-cycle swap.
- Swap: rd_sof with frame_ready=1 toggles rd_bank and wr_bank and clears frame_ready, effective the next cycle. rd_sof with frame_ready=0 does nothing.
- Completion and rd_sof in the same cycle: frame_ready sets and no swap occurs. The swap happens on the next rd_sof.
- Read: rd_data <= mem[rd_bank*C_IMG_PXLS + rd_addr], 1-cycle latency. In a swap cycle the read uses the pre-swap rd_bank.
- rd_addr >= C_IMG_PXLS gives rd_data = 0 next cycle.
- Read and write are independent each cycle. They never collide, because they target different banks.
- Reset mid-frame: all control state returns to reset values immediately. Memory contents are undefined for verification purposes.

Optional Feature:
FB_DECIMATE_EN
- Defined: the incoming stream is 2*C_IMG_COLS x 2*C_IMG_ROWS. Internal col and row counters, cleared on accepted wr_sof, track every wr_valid. The col counter wraps at 2*C_IMG_COLS and increments the row counter.
- Defined (continued): only pixels with even col and even row are written and advance wr_ptr. Completion occurs at the C_IMG_PXLS-th stored pixel.
- Undefined: no decimation counters; every wr_valid in W_FILL is stored.

Test Plan:
- Bench parameters for all scenarios: COLS=4, ROWS=2 (PXLS=8).
- Fill and swap: wr_sof, then 8 valid pixels 0x001..0x008. Expect frame_ready=1. Then rd_sof: expect rd_bank=1 and frame_ready=0. Then rd_addr=3: expect rd_data=0x004 one cycle later.
- Drop: complete a frame, issue no rd_sof, then a second wr_sof. Expect drop_cnt=1 and bank-1 contents unchanged. Two further drops give drop_cnt=3.
- Same-cycle swap and accept: frame_ready=1, then rd_sof, wr_sof and wr_valid (0xABC) together. Expect drop_cnt unchanged. After the next swap, rd_addr=0 returns 0xABC.
- Restart and out-of-range: wr_sof, 3 pixels, wr_sof, 8 pixels 0x010..0x017, then swap. Expect addr 0 = 0x010. rd_addr=9 gives rd_data=0.
- Async reset: assert rst_n=0 mid-W_FILL without a clock edge. Expect rd_data=0, rd_bank=0, frame_ready=0, drop_cnt=0 immediately.
- FB_DECIMATE_EN: 8x4 input frame with pixel value = index 0..31. Stored bank holds 0,2,4,6,16,18,20,22, and frame_ready sets after input pixel 22.
